// File: rtl/exp_pkg.sv
// Shared constants and types for expansion-port device selection.
// Used by the sequencer and by the expansion hub mux.
package exp_pkg;

    localparam int TYPE_W = 2;
    localparam int N_DEV  = 3;

    localparam logic [TYPE_W-1:0] EXP_OFF = 2'd0;
    localparam logic [TYPE_W-1:0] EXP_CDR = 2'd1;
    localparam logic [TYPE_W-1:0] EXP_TNB = 2'd2;

    typedef enum logic [1:0] {ACTIVE, DRAIN, OFF, RST} ExpSeqSt;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Every device held in reset except the selected one; bit 0 (OFF) is never driven.
    function automatic logic [N_DEV-1:0] dev_rst_for(input logic [TYPE_W-1:0] t);
        logic [N_DEV-1:0] m;
        m    = {N_DEV{1'b1}};
        m[0] = 1'b0;
        if (t != EXP_OFF) m[t] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/exp_seq_timer.sv
// Loadable down-counter with a zero flag; counts down by one per cycle and parks at zero.
module exp_seq_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/exp_sel_seq.sv
// Expansion-port device switch sequencer: debounce -> drain -> OFF guard -> target reset -> activate.
// act_type only ever moves on OFF entry (to EXP_OFF) or on ACTIVE entry (to the target).
module exp_sel_seq
    import exp_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int DRAIN_MAX  = 1024,
    parameter int GUARD_CYC  = 8,
    parameter int RST_CYC    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TYPE_W-1:0] req_type,
    input  logic              bus_busy,
    input  logic              err_clr,
    output logic [TYPE_W-1:0] act_type,
    output logic [N_DEV-1:0]  dev_rst,
    output logic              ready,
    output logic              drain_err
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(max3(DRAIN_MAX, GUARD_CYC, RST_CYC) + 1);

    localparam logic [SW-1:0]    STABLE_V = SW'(STABLE_CYC);
    localparam logic [TW-1:0]    DRAIN_LD = TW'(DRAIN_MAX - 1);
    localparam logic [TW-1:0]    GUARD_LD = TW'(GUARD_CYC - 1);
    localparam logic [TW-1:0]    RST_LD   = TW'(RST_CYC - 1);
    localparam logic [N_DEV-1:0] ALL_RST  = dev_rst_for(EXP_OFF);

    ExpSeqSt           state;
    logic [TYPE_W-1:0] req_d;
    logic [TYPE_W-1:0] req_n;
    logic [TYPE_W-1:0] target;
    logic [TYPE_W-1:0] tgt_nxt;
    logic [SW-1:0]     stable_cnt;
    logic              req_ok;
    logic              go_drain;
    logic              go_off;
    logic              go_rst;
    logic              go_act;
    logic              set_err;
    logic              tmr_load;
    logic              tmr_zero;
    logic [TW-1:0]     tmr_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d      <= EXP_OFF;
            stable_cnt <= '0;
        end else begin
            req_d <= req_type;
            if (req_type != req_d) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_V) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        req_n   = (req_type >= TYPE_W'(N_DEV)) ? EXP_OFF : req_type;
        // The request must still match its delayed copy, otherwise a saturated
        // counter would let a fresh glitch through.
        req_ok  = (stable_cnt == STABLE_V) && (req_type == req_d) && (req_n != target);
        tgt_nxt = req_ok ? req_n : target;

        go_drain = (state == ACTIVE) && req_ok;
        go_off   = ((state == DRAIN) && (!bus_busy || tmr_zero)) || ((state == RST) && req_ok);
        go_rst   = (state == OFF) && tmr_zero && (tgt_nxt != EXP_OFF);
        go_act   = ((state == OFF) && tmr_zero && (tgt_nxt == EXP_OFF)) ||
                   ((state == RST) && !req_ok && tmr_zero);
        set_err  = (state == DRAIN) && bus_busy && tmr_zero;

        tmr_load = go_drain || go_off || go_rst;
        tmr_val  = go_drain ? DRAIN_LD : (go_off ? GUARD_LD : RST_LD);
    end

    exp_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACTIVE;
            target    <= EXP_OFF;
            act_type  <= EXP_OFF;
            dev_rst   <= ALL_RST;
            ready     <= 1'b1;
            drain_err <= 1'b0;
        end else begin
            target <= tgt_nxt;
            if (go_drain) begin
                state <= DRAIN;
                ready <= 1'b0;
            end else if (go_off) begin
                state    <= OFF;
                act_type <= EXP_OFF;
                dev_rst  <= ALL_RST;
            end else if (go_rst) begin
                state <= RST;
            end else if (go_act) begin
                state    <= ACTIVE;
                act_type <= tgt_nxt;
                dev_rst  <= dev_rst_for(tgt_nxt);
                ready    <= 1'b1;
            end

            // A timeout in the same cycle as a clear leaves the error set.
            if (set_err) begin
                drain_err <= 1'b1;
            end else if (err_clr) begin
                drain_err <= 1'b0;
            end
        end
    end

endmodule
